// File: rtl/masked_share_encoder.sv
// Masking front end: splits plaintext operands A and B into two Boolean shares using fresh
// LFSR randomness and emits the gadget refresh bit, behind a single-entry valid/ready register.
module masked_share_encoder #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned LFSR_W = 16,
  parameter logic [63:0] SEED   = 64'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_A,
  input  logic [WIDTH-1:0]  i_B,
  input  logic              i_seed_load,
  input  logic [LFSR_W-1:0] i_seed,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WIDTH-1:0]  o_A0,
  output logic [WIDTH-1:0]  o_A1,
  output logic [WIDTH-1:0]  o_B0,
  output logic [WIDTH-1:0]  o_B1,
  output logic              o_r0,
  output logic [15:0]       o_count
);

  // Right-shifting Galois feedback masks for maximal-length polynomials.
  localparam logic [63:0] MaskFull = (LFSR_W == 16) ? 64'hB400 :
                                     (LFSR_W == 8)  ? 64'hB8   :
                                     (LFSR_W == 32) ? 64'h8020_0003 : 64'h0;
  localparam logic [LFSR_W-1:0] Mask     = MaskFull[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SeedInit = SEED[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] One      = {{(LFSR_W-1){1'b0}}, 1'b1};

  if (2 * WIDTH + 1 > LFSR_W) begin : g_width_check
    $error("LFSR_W too small for 2*WIDTH+1 mask bits");
  end
  if (SeedInit == '0) begin : g_seed_check
    $error("SEED must be nonzero");
  end
  if (MaskFull == 64'h0) begin : g_mask_check
    $error("no feedback mask defined for this LFSR_W");
  end

  typedef enum logic {StEmpty, StFull} state_e;

  state_e             state_q, state_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [WIDTH-1:0]   a0_q, a0_d, a1_q, a1_d, b0_q, b0_d, b1_q, b1_d;
  logic               r0_q, r0_d;
  logic [15:0]        count_q, count_d;
  logic               accept;

  assign o_ready = !i_seed_load && ((state_q == StEmpty) || i_ready);
  assign accept  = i_valid && o_ready;

  // Seed load wins over stepping; an all-zero seed would lock the LFSR up.
  always_comb begin
    if (i_seed_load) begin
      lfsr_d = (i_seed == '0) ? One : i_seed;
    end else begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Mask : '0);
    end
  end

  always_comb begin
    state_d = state_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    r0_d    = r0_q;
    count_d = count_q;

    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (!accept && i_ready) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase

    if (accept) begin
      a1_d    = lfsr_q[WIDTH-1:0];
      b1_d    = lfsr_q[2*WIDTH-1:WIDTH];
      a0_d    = i_A ^ lfsr_q[WIDTH-1:0];
      b0_d    = i_B ^ lfsr_q[2*WIDTH-1:WIDTH];
      r0_d    = lfsr_q[2*WIDTH];
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      lfsr_q  <= SeedInit;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      r0_q    <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      r0_q    <= r0_d;
      count_q <= count_d;
    end
  end

  assign o_valid = (state_q == StFull);
  assign o_A0    = a0_q;
  assign o_A1    = a1_q;
  assign o_B0    = b0_q;
  assign o_B1    = b1_q;
  assign o_r0    = r0_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_masked_share_encoder.sv
// Self-checking bench for masked_share_encoder: constant vectors, directed corner cases and
// randomized traffic against a cycle-level reference model.
module tb_masked_share_encoder;

  localparam int unsigned W     = 4;
  localparam int unsigned LW    = 16;
  localparam logic [15:0] SEEDV = 16'hACE1;
  localparam logic [15:0] MASK  = 16'hB400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_valid, i_ready, i_seed_load;
  logic [W-1:0]  i_A, i_B;
  logic [LW-1:0] i_seed;
  logic          o_ready, o_valid, o_r0;
  logic [W-1:0]  o_A0, o_A1, o_B0, o_B1;
  logic [15:0]   o_count;

  masked_share_encoder #(.WIDTH(W), .LFSR_W(LW), .SEED(64'hACE1)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_A(i_A), .i_B(i_B),
    .i_seed_load(i_seed_load), .i_seed(i_seed), .o_valid(o_valid), .i_ready(i_ready),
    .o_A0(o_A0), .o_A1(o_A1), .o_B0(o_B0), .o_B1(o_B1), .o_r0(o_r0), .o_count(o_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0]  m_lfsr;
  logic         m_valid, m_r0;
  logic [W-1:0] m_A0, m_A1, m_B0, m_B1, m_a, m_b;
  logic [15:0]  m_count;

  typedef struct {
    logic [15:0]  seed;
    logic [W-1:0] a, b, a0, a1, b0, b1;
    logic         r0;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ MASK) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_lfsr = SEEDV; m_valid = 0; m_r0 = 0; m_count = 0;
    m_A0 = 0; m_A1 = 0; m_B0 = 0; m_B1 = 0; m_a = 0; m_b = 0;
  endtask

  task automatic compare_outputs();
    check("o_valid", 32'(o_valid), 32'(m_valid));
    check("o_A0", 32'(o_A0), 32'(m_A0));
    check("o_A1", 32'(o_A1), 32'(m_A1));
    check("o_B0", 32'(o_B0), 32'(m_B0));
    check("o_B1", 32'(o_B1), 32'(m_B1));
    check("o_r0", 32'(o_r0), 32'(m_r0));
    check("o_count", 32'(o_count), 32'(m_count));
    if (m_valid) begin
      check("recombine_A", 32'(o_A0 ^ o_A1), 32'(m_a));
      check("recombine_B", 32'(o_B0 ^ o_B1), 32'(m_b));
    end
  endtask

  // One clock: check ready, advance model at the edge, compare registered outputs.
  task automatic tick();
    logic rdy, acc;
    #1;
    rdy = !i_seed_load && (!m_valid || i_ready);
    check("o_ready", 32'(o_ready), 32'(rdy));
    acc = i_valid && rdy;
    @(posedge clk);
    if (acc) begin
      m_A1 = m_lfsr[3:0];  m_B1 = m_lfsr[7:4];  m_r0 = m_lfsr[8];
      m_A0 = i_A ^ m_A1;   m_B0 = i_B ^ m_B1;
      m_a = i_A; m_b = i_B; m_valid = 1; m_count = m_count + 16'd1;
    end else if (m_valid && i_ready) begin
      m_valid = 0;
    end
    m_lfsr = i_seed_load ? ((i_seed == 0) ? 16'd1 : i_seed) : lfsr_step(m_lfsr);
    #1;
    compare_outputs();
  endtask

  task automatic drive(input logic v, input logic r, input logic sl);
    i_valid = v; i_ready = r; i_seed_load = sl;
    i_A = W'($urandom); i_B = W'($urandom);
  endtask

  logic [W-1:0] snap_a0, snap_a1, snap_b0, snap_b1;
  logic         snap_r0;
  logic [15:0]  snap_cnt, rseed;
  logic [8:0]   run1[8];
  int           zero_hits;

  initial begin
    tbl[0] = '{16'h0001, 4'hA, 4'h5, 4'hA, 4'h0, 4'h5, 4'h0, 1'b0};
    tbl[1] = '{16'h0000, 4'h3, 4'hC, 4'h3, 4'h0, 4'hC, 4'h0, 1'b0};
    tbl[2] = '{16'h0002, 4'h5, 4'h9, 4'h4, 4'h1, 4'h9, 4'h0, 1'b0};
    tbl[3] = '{16'hFFFE, 4'h6, 4'h3, 4'h9, 4'hF, 4'hC, 4'hF, 1'b1};
    tbl[4] = '{16'h0003, 4'hF, 4'h0, 4'hE, 4'h1, 4'h0, 4'h0, 1'b0};
    tbl[5] = '{16'h0200, 4'h7, 4'h8, 4'h7, 4'h0, 4'h8, 4'h0, 1'b1};
    tbl[6] = '{16'h00A4, 4'hC, 4'h1, 4'hE, 4'h2, 4'h4, 4'h5, 1'b0};

    rst_n = 0; i_valid = 0; i_ready = 0; i_seed_load = 0; i_seed = 0; i_A = 0; i_B = 0;
    model_reset();
    #23;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_shares", 32'({o_A0, o_A1, o_B0, o_B1, o_r0}), 32'd0);
    check("rst_o_count", 32'(o_count), 32'd0);
    @(negedge clk); rst_n = 1;
    #1 check("rst_o_ready", 32'(o_ready), 32'd1);

    // Stream of 20 words, one per cycle
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 0);
      tick();
    end
    check("stream_count", 32'(o_count), 32'd20);
    drive(0, 1, 0); tick();

    // Seed-load vectors: load, one idle step, then accept
    for (int i = 0; i < 7; i++) begin
      drive(1, 1, 1); i_seed = tbl[i].seed;
      tick();
      drive(0, 1, 0); tick();
      drive(1, 1, 0); i_A = tbl[i].a; i_B = tbl[i].b;
      tick();
      check("vec_A0", 32'(o_A0), 32'(tbl[i].a0));
      check("vec_A1", 32'(o_A1), 32'(tbl[i].a1));
      check("vec_B0", 32'(o_B0), 32'(tbl[i].b0));
      check("vec_B1", 32'(o_B1), 32'(tbl[i].b1));
      check("vec_r0", 32'(o_r0), 32'(tbl[i].r0));
      drive(0, 1, 0); tick();
    end

    // Backpressure: hold FULL for 5 cycles while new words are offered
    drive(1, 1, 0); tick();
    snap_a0 = m_A0; snap_a1 = m_A1; snap_b0 = m_B0; snap_b1 = m_B1; snap_r0 = m_r0;
    snap_cnt = m_count;
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0); tick();
      check("bp_stable", 32'({o_A0, o_A1, o_B0, o_B1, o_r0}),
            32'({snap_a0, snap_a1, snap_b0, snap_b1, snap_r0}));
      check("bp_count", 32'(o_count), 32'(snap_cnt));
      check("bp_ready", 32'(o_ready), 32'd0);
    end
    drive(1, 1, 0); tick();
    check("bp_release_count", 32'(o_count), 32'(snap_cnt + 16'd1));

    // Seed load while FULL: drains with i_ready=1, holds with i_ready=0
    drive(1, 0, 1); i_seed = 16'h1234; tick();
    check("sl_hold_valid", 32'(o_valid), 32'd1);
    drive(1, 1, 1); i_seed = 16'h4321; tick();
    check("sl_drain_valid", 32'(o_valid), 32'd0);

    // Random mix of valid, ready and occasional seed loads
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
      i_seed = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      tick();
    end

    // Same seed twice yields the same share sequence
    rseed = 16'($urandom) | 16'h1;
    for (int pass = 0; pass < 2; pass++) begin
      drive(0, 1, 1); i_seed = rseed; tick();
      for (int i = 0; i < 8; i++) begin
        drive(1, 1, 0); tick();
        if (pass == 0) run1[i] = {m_r0, m_B1, m_A1};
        else check("reseed_repeat", 32'({o_r0, o_B1, o_A1}), 32'(run1[i]));
      end
    end

    // Zero seed: LFSR must never reach zero over more than a full period
    drive(0, 1, 1); i_seed = 16'h0; tick();
    zero_hits = 0;
    for (int i = 0; i < 70000; i++) begin
      drive(1, 1, 0); tick();
      if (dut.lfsr_q == 16'h0) zero_hits++;
    end
    check("lfsr_never_zero", 32'(zero_hits), 32'd0);

    // Asynchronous reset while FULL
    drive(1, 0, 0); tick();
    drive(1, 0, 0); tick();
    #2 rst_n = 0;
    #1;
    check("arst_o_valid", 32'(o_valid), 32'd0);
    check("arst_o_count", 32'(o_count), 32'd0);
    check("arst_shares", 32'({o_A0, o_A1, o_B0, o_B1, o_r0}), 32'd0);
    model_reset();
    drive(0, 1, 0);
    @(negedge clk); @(negedge clk); rst_n = 1;
    #1 check("arst_lfsr_seed", 32'(dut.lfsr_q), 32'(SEEDV));
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 0); tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
